// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the Hack data-RAM arbiter.
// Holds the sequencer states, the requester identities, the CPU address regions and the memory-map constants.
package hack_mem_pkg;

    localparam logic [14:0] DEF_SCREEN_BASE = 15'h4000;
    localparam logic [14:0] DEF_KBD_ADDR    = 15'h6000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        RGN_RAM      = 2'd0,
        RGN_KBD      = 2'd1,
        RGN_UNMAPPED = 2'd2
    } region_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_CPU) ? OWN_VID : OWN_CPU;
    endfunction

endpackage

// File: rtl/hack_mem_arbiter_arb.sv
// Two-requester round-robin grant for the Hack memory arbiter.
// The priority register only moves when a grant is actually made.
module hack_rr_arb2
    import hack_mem_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   cpu_req,
    input  logic   vid_req,
    output logic   grant,
    output owner_e grant_owner
);

    owner_e prio_q;
    owner_e prio_d;

    // On a tie, prio picks the winner; any grant hands priority to the loser.
    always_comb begin
        grant       = 1'b0;
        grant_owner = OWN_VID;
        prio_d      = prio_q;
        if (en) begin
            if (cpu_req && vid_req) begin
                grant       = 1'b1;
                grant_owner = prio_q;
            end else if (cpu_req) begin
                grant       = 1'b1;
                grant_owner = OWN_CPU;
            end else if (vid_req) begin
                grant       = 1'b1;
                grant_owner = OWN_VID;
            end
            if (grant) begin
                prio_d = other_owner(grant_owner);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= OWN_VID;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Shares the single-port data RAM between the CPU data port and video scanout.
// Each access takes IDLE -> ISSUE -> RESP; the CPU side also decodes the keyboard register and the unmapped space.
module hack_mem_arbiter
    import hack_mem_pkg::*;
#(
    parameter int                ADDR_W      = 15,
    parameter int                DATA_W      = 16,
    parameter int                VID_AW      = 13,
    parameter logic [ADDR_W-1:0] SCREEN_BASE = ADDR_W'(DEF_SCREEN_BASE),
    parameter logic [ADDR_W-1:0] KBD_ADDR    = ADDR_W'(DEF_KBD_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_bad_addr,
    input  logic              vid_req,
    input  logic [VID_AW-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
    input  logic [DATA_W-1:0] kbd_in,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    region_e           region_q, region_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] kbd_q, kbd_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;

    logic              arb_en;
    logic              grant;
    owner_e            grant_owner;
    region_e           cpu_region;
    logic [ADDR_W-1:0] vid_full_addr;
    logic [DATA_W-1:0] resp_data;
    logic              resp_cpu;
    logic              resp_vid;
    logic              resp_read;

    assign arb_en        = (state_q == ST_IDLE);
    assign vid_full_addr = SCREEN_BASE + ADDR_W'(vid_addr);

    hack_rr_arb2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .en          (arb_en),
        .cpu_req     (cpu_req),
        .vid_req     (vid_req),
        .grant       (grant),
        .grant_owner (grant_owner)
    );

    always_comb begin
        cpu_region = RGN_UNMAPPED;
        if (cpu_addr < KBD_ADDR) begin
            cpu_region = RGN_RAM;
        end else if (cpu_addr == KBD_ADDR) begin
            cpu_region = RGN_KBD;
        end
    end

    // Everything about an access is latched at grant, so requesters only need to hold until ack.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        region_d    = region_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        kbd_d       = kbd_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d = grant_owner;
                    state_d = ST_ISSUE;
                    if (grant_owner == OWN_VID) begin
                        we_d     = 1'b0;
                        addr_d   = vid_full_addr;
                        wdata_d  = '0;
                        region_d = RGN_RAM;
                    end else begin
                        we_d     = cpu_we;
                        addr_d   = cpu_addr;
                        wdata_d  = cpu_wdata;
                        region_d = cpu_region;
                    end
                end
            end
            ST_ISSUE: begin
                if (region_q == RGN_KBD) begin
                    kbd_d = kbd_in;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_read) begin
                    if (owner_q == OWN_CPU) begin
                        cpu_rdata_d = resp_data;
                    end else begin
                        vid_rdata_d = resp_data;
                    end
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the current state only, so a write already on the bus still lands if reset arrives mid-cycle.
    always_comb begin
        mem_en       = (state_q == ST_ISSUE) && (region_q == RGN_RAM);
        mem_we       = mem_en && we_q;
        mem_addr     = mem_en ? addr_q : '0;
        mem_wdata    = mem_en ? wdata_q : '0;
        resp_cpu     = (state_q == ST_RESP) && (owner_q == OWN_CPU);
        resp_vid     = (state_q == ST_RESP) && (owner_q == OWN_VID);
        resp_read    = (state_q == ST_RESP) && !we_q;
        cpu_ack      = resp_cpu;
        vid_ack      = resp_vid;
        cpu_bad_addr = resp_cpu && (region_q == RGN_UNMAPPED);
        case (region_q)
            RGN_RAM: resp_data = mem_rdata;
            RGN_KBD: resp_data = kbd_q;
            default: resp_data = '0;
        endcase
        cpu_rdata = (resp_cpu && !we_q) ? resp_data : cpu_rdata_q;
        vid_rdata = resp_vid ? resp_data : vid_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            region_q    <= RGN_RAM;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            kbd_q       <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            region_q    <= region_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            kbd_q       <= kbd_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

endmodule
